// File: rtl/sync_fifo_pkg.sv
// Shared types, default parameters and helpers for the parametrised FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_FWFT      = 0;

  // Status flags, all decoded from the registered occupancy count.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_status_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// programmable almost thresholds, occupancy count and sticky error flags.
//
// Handshake: push is taken on a rising edge iff push && !full; pop is taken iff
// pop && !empty. A refused push drops its data and sets overflow; a refused pop
// leaves rdata alone and sets underflow. There is no back-pressure beyond
// full/empty, and both sides may transfer every cycle.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int FWFT      = DEF_FWFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: WIDTH must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_rdata;
  logic             push_ok;
  logic             pop_ok;
  fifo_status_t     status;

  // Flags come only from the registered count, so they move on clock edges only.
  assign status = '{
    full:         (count_q == DEPTH_C),
    almost_full:  (count_q >= AF_C),
    empty:        (count_q == '0),
    almost_empty: (count_q <= AE_C)
  };

  assign full         = status.full;
  assign almost_full  = status.almost_full;
  assign empty        = status.empty;
  assign almost_empty = status.almost_empty;
  assign count        = count_q;

  assign push_ok = push && !status.full;
  assign pop_ok  = pop  && !status.empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: a simultaneous accepted push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && status.full) overflow <= 1'b1;
      else if (clr_err)        overflow <= 1'b0;
      if (pop && status.empty) underflow <= 1'b1;
      else if (clr_err)        underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is visible directly; meaningless while empty.
    assign rdata = mem_rdata;
  end else begin : g_reg_read
    logic [WIDTH-1:0] rdata_q;

    // Registered read: capture the head word on each accepted pop.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       rdata_q <= '0;
      else if (pop_ok) rdata_q <= mem_rdata;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's 8-bit FIFO, generalised in data width and depth, with selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain. Its push/pop/full/empty signal set matches the existing FIFO interfaces, so current drivers and monitors attach unchanged.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- push  in  1  write request
- wdata  in  WIDTH  write data, sampled when push is accepted
- pop  in  1  read request
- rdata  out  WIDTH  read data
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_THRESH
- empty  out  1  count == 0
- almost_empty  out  1  count <= AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- overflow  out  1  sticky: a push arrived while full
- underflow  out  1  sticky: a pop arrived while empty
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Push accepted iff push && !full: write wdata at wr_ptr, then wr_ptr++.
- Pop accepted iff pop && !empty: rd_ptr++.
- Both pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count updates: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Simultaneous push+pop:
  - 0<count<DEPTH: both accepted, count unchanged.
  - count==0: push accepted, pop rejected, underflow set.
  - count==DEPTH: pop accepted, push rejected, overflow set.
- Rejected push: data dropped, memory and pointers untouched, overflow <= 1.
- Rejected pop: rdata holds its value, underflow <= 1.
- Sticky flags: clr_err clears both; if an error event occurs in the same cycle as clr_err, set wins.
- FWFT=0: on an accepted pop, rdata <= mem[rd_ptr] on that edge. rdata then holds until the next accepted pop.
- FWFT=1: rdata = mem[rd_ptr], combinational from registered pointer/memory, valid whenever !empty. pop consumes the word. rdata is don't-care while empty.
- All status flags decode from registered count, so they are glitch-free and change only on clock edges.

## Timing
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rdata=0 (FWFT=0), pointers=0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately (asynchronously); the first push after deassertion is accepted normally.
- Write latency: a word pushed on edge N makes empty deassert after edge N.
  - FWFT=1: the word is on rdata in cycle N+1.
  - FWFT=0: pop may be issued in cycle N+1; data appears after the following edge (1-cycle read latency).
- full asserts on the edge that accepts the DEPTH-th word; it deasserts on the edge that accepts the next pop.
- Throughput: one push and one pop per cycle, sustained, with no bubbles.

## Structure
- Package sync_fifo_pkg holds:
  - fifo_status_t, a packed struct {full, almost_full, empty, almost_empty}
  - the default parameter constants
  - a function cnt_w(depth) returning $clog2(depth)+1
- Sub-module fifo_mem holds the storage: simple dual-port array, one write port and one asynchronous read port, WIDTH x DEPTH, no reset.
- The top level holds the pointers, count, flag decode, error flags and the FWFT/registered output mux (generate on FWFT).
- Elaboration-time assertions check DEPTH is a power of two and both thresholds are in range.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F (DEPTH=16, FWFT=0), then 16 pops -> rdata 0x00..0x0F in order, each one cycle after its pop. full asserts after the 16th push; empty asserts after the 16th pop.
- Fill to 16, then push 0xAA -> overflow=1, count stays 16, 0xAA never read back. clr_err -> overflow=0.
- Pop while empty -> underflow=1, rdata unchanged, count stays 0. clr_err pulsed together with a second empty pop -> underflow stays 1.
- Hold count at 8 with push+pop every cycle for 40 cycles (pointer wrap) -> count stays 8, data order preserved, no flags set.
- FWFT=1: push 0x5C into an empty FIFO -> rdata=0x5C and empty=0 one cycle later with no pop. Pop -> empty=1.
- Ramp count 0->16->0 with AF_THRESH=14, AE_THRESH=2 -> almost_full exactly at counts 14..16, almost_empty exactly at counts 0..2. Assert reset at count 9 -> all outputs return to reset values at once.
